daisychain_master: RTL and testbench

//  Host-side sequencer for the daisychain bidirectional serial line.
//  - Accepts one command/data request at a time from a local requester (valid/ready).
//  - Serialises start bit, command and write data onto data_inout.
//  - Releases the line for read responses and returns the captured word.
//  - Sits between host/bus logic and the first serial_ctrl slave in the chain.

---
 rtl/daisychain_master_pkg.sv | 46 ++++
 rtl/daisychain_master_shifter.sv | 38 +++
 rtl/daisychain_master.sv | 204 ++++++++++++++++++++
 tb/tb_daisychain_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/daisychain_master_pkg.sv
// Shared definitions for the daisychain serial line: command codes, state types
// and default phase lengths used by the host-side master and the chain slaves.
package daisychain_master_pkg;

    localparam int CMD_LEN  = 2;
    localparam int DATA_LEN = 8;

    localparam logic [1:0] RESET_CMD     = 2'b00;
    localparam logic [1:0] START_SND_CMD = 2'b01;
    localparam logic [1:0] START_RCV_CMD = 2'b10;
    localparam logic [1:0] UPDATE_CMD    = 2'b11;

    localparam int ACK_CYCLES_DEF   = 2;
    localparam int TURN_CYCLES_DEF  = 2;
    localparam int GUARD_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        CTRL_IDLE,
        CTRL_CMD,
        CTRL_ACK,
        CTRL_DATA,
        CTRL_GUARD
    } ctrl_state_t;

    typedef enum logic [3:0] {
        QUIET,
        IDLE,
        START,
        CMD,
        ACK,
        WRITE,
        TURN,
        READ,
        GUARD
    } master_state_t;

    function automatic logic cmd_is_legal(input logic [31:0] cmd);
        return (cmd == 32'(RESET_CMD))     || (cmd == 32'(START_SND_CMD)) ||
               (cmd == 32'(START_RCV_CMD)) || (cmd == 32'(UPDATE_CMD));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/daisychain_master_shifter.sv
// Parallel-load shift register: MSB-first shift-out for command/write phases,
// LSB-side shift-in for the read phase.
module daisychain_master_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             shift_in_i,
    output logic             msb_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_val_i;
        end else if (shift_i) begin
            sh_d = {sh_q[WIDTH-2:0], shift_in_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb_o = sh_q[WIDTH-1];
    assign q_o   = sh_q;

endmodule

// File: rtl/daisychain_master.sv
// Host-side sequencer for the daisychain line: start bit, command, ack gap,
// then a write or read data phase, and a guard gap before the response.
module daisychain_master
    import daisychain_master_pkg::*;
#(
    parameter int CMD_BITS     = CMD_LEN,
    parameter int DATA_BITS    = DATA_LEN,
    parameter int ACK_CYCLES   = ACK_CYCLES_DEF,
    parameter int TURN_CYCLES  = TURN_CYCLES_DEF,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
    parameter int RESYNC       = CMD_BITS + DATA_BITS + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CMD_BITS-1:0]  req_cmd,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 busy,
    inout  wire                  data_inout
);

    localparam int SH_W    = max2(CMD_BITS, DATA_BITS);
    localparam int MAX_LEN = max2(max2(RESYNC, SH_W),
                                  max2(ACK_CYCLES, max2(TURN_CYCLES, GUARD_CYCLES)));
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LEN_RESYNC = cnt_t'(RESYNC - 1);
    localparam cnt_t LEN_CMD    = cnt_t'(CMD_BITS - 1);
    localparam cnt_t LEN_DATA   = cnt_t'(DATA_BITS - 1);
    localparam cnt_t LEN_ACK    = cnt_t'(ACK_CYCLES - 1);
    localparam cnt_t LEN_TURN   = cnt_t'(TURN_CYCLES - 1);
    localparam cnt_t LEN_GUARD  = cnt_t'(GUARD_CYCLES - 1);

    master_state_t        state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    logic [CMD_BITS-1:0]  cmd_q, cmd_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 sh_load, sh_shift, sh_in, sh_msb;
    logic [SH_W-1:0]      sh_load_val, sh_q;
    logic                 drive_en, drive_bit;

    daisychain_master_shifter #(
        .WIDTH(SH_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (sh_load),
        .load_val_i(sh_load_val),
        .shift_i   (sh_shift),
        .shift_in_i(sh_in),
        .msb_o     (sh_msb),
        .q_o       (sh_q)
    );

    assign sh_in = (state_q == READ) ? data_inout : 1'b0;

    // Every phase reloads the counter with (length - 1) and ends when it reads zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == '0) ? '0 : cnt_q - cnt_t'(1);
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        sh_load     = 1'b0;
        sh_load_val = '0;
        sh_shift    = 1'b0;
        case (state_q)
            QUIET: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    if (cmd_is_legal(32'(req_cmd))) begin
                        state_d     = START;
                        cnt_d       = '0;
                        cmd_d       = req_cmd;
                        wdata_d     = req_wdata;
                        sh_load     = 1'b1;
                        sh_load_val = SH_W'(req_cmd) << (SH_W - CMD_BITS);
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            START: begin
                state_d = CMD;
                cnt_d   = LEN_CMD;
            end
            CMD: begin
                sh_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ACK;
                    cnt_d   = LEN_ACK;
                end
            end
            ACK: begin
                if (cnt_q == '0) begin
                    if (32'(cmd_q) == 32'(START_RCV_CMD)) begin
                        state_d     = WRITE;
                        cnt_d       = LEN_DATA;
                        sh_load     = 1'b1;
                        sh_load_val = SH_W'(wdata_q) << (SH_W - DATA_BITS);
                    end else if (32'(cmd_q) == 32'(START_SND_CMD)) begin
                        state_d = TURN;
                        cnt_d   = LEN_TURN;
                    end else begin
                        state_d = GUARD;
                        cnt_d   = LEN_GUARD;
                    end
                end
            end
            WRITE: begin
                sh_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GUARD;
                    cnt_d   = LEN_GUARD;
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = READ;
                    cnt_d   = LEN_DATA;
                end
            end
            READ: begin
                sh_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GUARD;
                    cnt_d   = LEN_GUARD;
                end
            end
            GUARD: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    if (32'(cmd_q) == 32'(START_SND_CMD)) begin
                        rdata_d = sh_q[DATA_BITS-1:0];
                    end
                end
            end
            default: begin
                state_d = QUIET;
                cnt_d   = LEN_RESYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= QUIET;
            cnt_q       <= LEN_RESYNC;
            cmd_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Decoded straight from state so an async reset pulls the line low at once.
    always_comb begin
        drive_en  = (state_q != TURN) && (state_q != READ);
        drive_bit = 1'b0;
        if (state_q == START) begin
            drive_bit = 1'b1;
        end else if ((state_q == CMD) || (state_q == WRITE)) begin
            drive_bit = sh_msb;
        end
    end

    assign data_inout = drive_en ? drive_bit : 1'bZ;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_daisychain_master.sv
// Randomized self-checking bench for daisychain_master against a per-cycle
// expected-line model built from the protocol's phase rules.
module tb_daisychain_master;
    import daisychain_master_pkg::*;

    localparam int CB     = 2;
    localparam int DB     = 8;
    localparam int ACKN   = 2;
    localparam int TURNN  = 2;
    localparam int GUARDN = 2;
    localparam int RESYNC = CB + DB + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CB-1:0] req_cmd = '0;
    logic [DB-1:0] req_wdata = '0;
    logic          rsp_valid, rsp_err, busy;
    logic [DB-1:0] rsp_rdata;
    wire           line;
    logic          tb_en = 1'b0;
    logic          tb_bit = 1'b0;

    logic          req_valid2 = 1'b0;
    logic          req_ready2;
    logic [2:0]    req_cmd2 = '0;
    logic [DB-1:0] req_wdata2 = '0;
    logic          rsp_valid2, rsp_err2, busy2;
    logic [DB-1:0] rsp_rdata2;
    wire           line2;

    int            n_tests = 0;
    int            n_fail = 0;
    int            exp_q[$];
    logic [DB-1:0] last_rdata = '0;

    assign line = tb_en ? tb_bit : 1'bz;

    always #5 clk = ~clk;

    daisychain_master #(
        .CMD_BITS (CB),
        .DATA_BITS(DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .data_inout(line)
    );

    daisychain_master #(
        .CMD_BITS (3),
        .DATA_BITS(DB)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid2),
        .req_ready (req_ready2),
        .req_cmd   (req_cmd2),
        .req_wdata (req_wdata2),
        .rsp_valid (rsp_valid2),
        .rsp_err   (rsp_err2),
        .rsp_rdata (rsp_rdata2),
        .busy      (busy2),
        .data_inout(line2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line per cycle after the handshake: 0/1 driven, 2 released.
    task automatic build_exp(input logic [CB-1:0] cmd, input logic [DB-1:0] wd);
        exp_q.delete();
        exp_q.push_back(1);
        for (int i = CB - 1; i >= 0; i--) exp_q.push_back(int'(cmd[i]));
        repeat (ACKN) exp_q.push_back(0);
        if (cmd == START_RCV_CMD) begin
            for (int i = DB - 1; i >= 0; i--) exp_q.push_back(int'(wd[i]));
        end else if (cmd == START_SND_CMD) begin
            repeat (TURNN + DB) exp_q.push_back(2);
        end
        repeat (GUARDN) exp_q.push_back(0);
    endtask

    task automatic reset_and_quiet(input bit already_in_reset);
        if (!already_in_reset) begin
            reset = 1'b1;
            #1;
        end
        last_rdata = '0;
        check("rst_rsp", {rsp_valid, rsp_err, busy, req_ready}, 4'b0010);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_line", {dut.drive_en, line}, 2'b10);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 1; k <= RESYNC; k++) begin
            @(negedge clk);
            check("quiet", {req_ready, busy, dut.drive_en, line}, 4'b0110);
        end
        @(negedge clk);
        check("quiet_done", {req_ready, busy}, 2'b10);
    endtask

    task automatic do_txn(input logic [CB-1:0] cmd, input logic [DB-1:0] wd,
                          input logic [DB-1:0] rd, input int abort_at);
        int n;
        int zi;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_wdata = wd;
        build_exp(cmd, wd);
        zi = 0;
        @(posedge clk);
        for (int k = 1; k <= exp_q.size(); k++) begin
            #1;
            if (k == 1) begin
                req_valid = 1'b0;
                req_cmd   = CB'($urandom);
                req_wdata = DB'($urandom);
            end
            tb_en = 1'b0;
            if (exp_q[k-1] == 2) begin
                if (zi >= TURNN) begin
                    tb_en  = 1'b1;
                    tb_bit = rd[DB-1-(zi-TURNN)];
                end
                zi++;
            end
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check("abort_line", {dut.drive_en, line}, 2'b10);
                check("abort_state", {busy, req_ready, rsp_valid}, 3'b100);
                return;
            end
            @(negedge clk);
            if (exp_q[k-1] == 2) check("line_released", dut.drive_en, 0);
            else check("line_bit", {dut.drive_en, line}, {1'b1, exp_q[k-1][0]});
            check("busy", {busy, req_ready, rsp_valid}, 3'b100);
            @(posedge clk);
        end
        #1 tb_en = 1'b0;
        if (cmd == START_SND_CMD) last_rdata = rd;
        @(negedge clk);
        check("rsp", {rsp_valid, rsp_err, busy, req_ready}, 4'b1001);
        check("rdata", rsp_rdata, last_rdata);
    endtask

    task automatic illegal_on_dut2();
        int n;
        n = 0;
        while (!req_ready2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("dut2_ready", req_ready2, 1);
        req_valid2 = 1'b1;
        req_cmd2   = 3'b100;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        @(negedge clk);
        check("illegal_rsp", {rsp_valid2, rsp_err2, req_ready2, busy2}, 4'b1110);
        check("illegal_line", {dut2.drive_en, line2}, 2'b10);
        check("illegal_rdata", rsp_rdata2, 0);
        @(negedge clk);
        check("illegal_clear", {rsp_valid2, rsp_err2, busy2, dut2.drive_en, line2}, 5'b00010);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        reset_and_quiet(1'b0);
        illegal_on_dut2();

        do_txn(START_RCV_CMD, 8'hA5, 8'h00, 0);
        do_txn(START_SND_CMD, 8'h00, 8'h3C, 0);
        do_txn(UPDATE_CMD, 8'hFF, 8'h00, 0);
        do_txn(RESET_CMD, 8'h5A, 8'h00, 0);

        do_txn(START_RCV_CMD, 8'hC3, 8'h00, 10);
        reset_and_quiet(1'b1);
        do_txn(START_SND_CMD, 8'h00, 8'h96, 0);

        for (int t = 0; t < 24; t++) begin
            do_txn(CB'($urandom_range(0, 3)), DB'($urandom), DB'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
